reg4_bus_master: RTL and testbench

Command-driven initiator for the 4-entry, 16-bit register-bank bus (sel/wr/addr/wdata/rdata, registered read data). It accepts single or burst read/write commands over a valid/ready port, streams write data in, and returns read data out. It drives the bank's bus pins cycle-accurately, so firmware-side logic never touches raw strobes.

---
 rtl/reg4_bus_master.sv | 151 +++++++++++++++
 tb/tb_reg4_bus_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg4_bus_master.sv
// Command-driven initiator for the 4-entry register-bank bus.
// Runs single/burst reads and writes and drives registered bank strobes.
module reg4_bus_master #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              bus_sel,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int unsigned BEATS_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_CAPT,
        S_RD_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [BEATS_W-1:0]  beats_q, beats_d;
    logic                bus_sel_q, bus_sel_d;
    logic                bus_wr_q, bus_wr_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    // Marks the cycle right after a reset edge so no command is taken while reset is held.
    logic                rst_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            beats_q     <= '0;
            bus_sel_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rd_data_q   <= '0;
            rst_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            beats_q     <= beats_d;
            bus_sel_q   <= bus_sel_d;
            bus_wr_q    <= bus_wr_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rd_data_q   <= rd_data_d;
            rst_q       <= 1'b0;
        end
    end

    // Handshake readiness decoded from registered state only.
    assign cmd_ready = (state_q == S_IDLE) && !rst_q;
    assign wd_ready  = (state_q == S_WR);
    assign rd_valid  = (state_q == S_RD_RESP);
    assign rd_last   = rd_valid && (beats_q == BEATS_W'(1));
    assign busy      = (state_q != S_IDLE);

    assign bus_sel   = bus_sel_q;
    assign bus_wr    = bus_wr_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rd_data   = rd_data_q;

    // Strobes are set one cycle ahead so they appear registered in the target cycle.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        beats_d     = beats_q;
        bus_sel_d   = 1'b0;
        bus_wr_d    = 1'b0;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rd_data_d   = rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cur_d   = cmd_addr;
                    beats_d = BEATS_W'(cmd_len) + BEATS_W'(1);
                    if (cmd_wr) begin
                        state_d = S_WR;
                    end else begin
                        state_d    = S_RD_ISSUE;
                        bus_sel_d  = 1'b1;
                        bus_addr_d = cmd_addr;
                    end
                end
            end
            S_WR: begin
                if (wd_valid) begin
                    bus_sel_d   = 1'b1;
                    bus_wr_d    = 1'b1;
                    bus_addr_d  = cur_q;
                    bus_wdata_d = wd_data;
                    cur_d       = cur_q + ADDR_W'(1);
                    beats_d     = beats_q - BEATS_W'(1);
                    if (beats_q == BEATS_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_CAPT;
            end
            S_RD_CAPT: begin
                rd_data_d = bus_rdata;
                state_d   = S_RD_RESP;
            end
            S_RD_RESP: begin
                if (rd_ready) begin
                    beats_d = beats_q - BEATS_W'(1);
                    if (beats_q == BEATS_W'(1)) begin
                        state_d = S_IDLE;
                    end else begin
                        cur_d      = cur_q + ADDR_W'(1);
                        bus_sel_d  = 1'b1;
                        bus_addr_d = cur_q + ADDR_W'(1);
                        state_d    = S_RD_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg4_bus_master.sv
// Bench for reg4_bus_master: bank model on the bus pins, expected-contents array,
// directed scenarios plus randomized read/write bursts.
module tb_reg4_bus_master;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready, cmd_wr;
    logic [ADDR_W-1:0] cmd_addr, cmd_len;
    logic              wd_valid, wd_ready;
    logic [DATA_W-1:0] wd_data;
    logic              rd_valid, rd_ready, rd_last;
    logic [DATA_W-1:0] rd_data;
    logic              busy, bus_sel, bus_wr;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata, bus_rdata;

    logic              bank_load;
    logic [DATA_W-1:0] bank    [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg4_bus_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .bus_sel   (bus_sel),
        .bus_wr    (bus_wr),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    // Register bank: writes on the edge ending a write pulse, registered read data.
    always @(posedge clk) begin
        if (bank_load) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= 16'(16'hA000 + i);
            bus_rdata <= '0;
        end else begin
            if (bus_sel && bus_wr) bank[bus_addr] <= bus_wdata;
            if (bus_sel && !bus_wr) bus_rdata <= bank[bus_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // base != 0 gives data base*(beat+1); base == 0 gives random data.
    task automatic do_write(input logic [1:0] a, input logic [1:0] len,
                            input logic [15:0] base, input int max_gap);
        logic [15:0] d;
        int          ea;
        int          g;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = a; cmd_len = len;
        check("wr_cmd_ready", cmd_ready, 1);
        step;
        cmd_valid = 1'b0; cmd_addr = 2'($urandom); cmd_len = 2'($urandom);
        check("wr_busy", busy, 1);
        check("wr_cmd_ready_busy", cmd_ready, 0);
        for (int i = 0; i <= int'(len); i++) begin
            ea = (int'(a) + i) % DEPTH;
            g  = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                wd_valid = 1'b0; wd_data = 16'($urandom);
                step;
                check("wr_gap_sel", bus_sel, 0);
            end
            d = (base != 16'h0) ? 16'(base * (i + 1)) : 16'($urandom);
            wd_valid = 1'b1; wd_data = d;
            check("wr_wd_ready", wd_ready, 1);
            step;
            check("wr_sel_wr", {bus_sel, bus_wr}, 2'b11);
            check("wr_addr", bus_addr, 32'(ea));
            check("wr_wdata", bus_wdata, d);
            ref_mem[ea] = d;
        end
        wd_valid = 1'b0;
        check("wr_done_cmd_ready", cmd_ready, 1);
        check("wr_done_busy", busy, 0);
        check("wr_done_wd_ready", wd_ready, 0);
    endtask

    task automatic do_read(input logic [1:0] a, input logic [1:0] len, input int max_stall,
                           input int stall_beat, input int stall_n, input bit stray);
        int          ea;
        int          s;
        logic [15:0] exp_d;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a; cmd_len = len;
        check("rd_cmd_ready", cmd_ready, 1);
        step;
        cmd_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            ea    = (int'(a) + i) % DEPTH;
            exp_d = ref_mem[ea];
            if (stray) begin
                cmd_valid = 1'($urandom); cmd_wr = 1'($urandom);
                wd_valid  = 1'($urandom);
            end
            rd_ready = 1'($urandom);
            check("rd_issue_sel_wr", {bus_sel, bus_wr}, 2'b10);
            check("rd_issue_addr", bus_addr, 32'(ea));
            check("rd_issue_valid", rd_valid, 0);
            check("rd_issue_cmd_ready", cmd_ready, 0);
            check("rd_issue_wd_ready", wd_ready, 0);
            step;
            rd_ready = 1'($urandom);
            check("rd_capt_sel", bus_sel, 0);
            check("rd_capt_valid", rd_valid, 0);
            step;
            check("rd_valid", rd_valid, 1);
            check("rd_data", rd_data, exp_d);
            check("rd_last", rd_last, (i == int'(len)) ? 1 : 0);
            s = (i == stall_beat) ? stall_n :
                (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
            for (int k = 0; k < s; k++) begin
                rd_ready = 1'b0;
                step;
                check("rd_stall_valid", rd_valid, 1);
                check("rd_stall_data", rd_data, exp_d);
                check("rd_stall_last", rd_last, (i == int'(len)) ? 1 : 0);
                check("rd_stall_sel", bus_sel, 0);
                check("rd_stall_cmd_ready", cmd_ready, 0);
            end
            rd_ready = 1'b1;
            step;
            rd_ready = 1'b0;
        end
        cmd_valid = 1'b0; wd_valid = 1'b0;
        check("rd_done_cmd_ready", cmd_ready, 1);
        check("rd_done_busy", busy, 0);
        check("rd_done_valid", rd_valid, 0);
    endtask

    task automatic idle_stray;
        wd_valid = 1'b1; wd_data = 16'($urandom);
        check("idle_wd_ready", wd_ready, 0);
        step;
        check("idle_stray_sel", bus_sel, 0);
        check("idle_stray_busy", busy, 0);
        step;
        check("idle_stray_sel2", bus_sel, 0);
        wd_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] d0, d1;
        reset = 1'b1; bank_load = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'(16'hA000 + i);
        step;
        step;
        bank_load = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_sel_wr", {bus_sel, bus_wr}, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_rd", {rd_valid, rd_last}, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wd_ready", wd_ready, 0);
        check("rst_cmd_ready_held", cmd_ready, 0);
        reset = 1'b0;
        step;
        check("rst_release_cmd_ready", cmd_ready, 1);

        // Single write then read-back of address 2.
        do_write(2'd2, 2'd0, 16'hBEEF, 0);
        do_read(2'd2, 2'd0, 0, -1, 0, 1'b0);

        // Wrapping back-to-back write burst 3,0,1,2.
        do_write(2'd3, 2'd3, 16'h1111, 0);
        do_read(2'd0, 2'd3, 0, -1, 0, 1'b0);

        // Read burst 1..3 with beat 2 stalled five cycles, stray inputs active.
        do_read(2'd1, 2'd2, 0, 1, 5, 1'b1);
        idle_stray;

        // Reset after two of four write handshakes.
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 2'd0; cmd_len = 2'd3;
        step;
        cmd_valid = 1'b0;
        d0 = 16'h5A01; d1 = 16'h5A02;
        wd_valid = 1'b1; wd_data = d0;
        step;
        wd_data = d1;
        step;
        check("mid_sel_before_rst", bus_sel, 1);
        ref_mem[0] = d0; ref_mem[1] = d1;
        reset = 1'b1; wd_data = 16'h7777;
        step;
        check("mid_rst_sel", bus_sel, 0);
        check("mid_rst_wdata", bus_wdata, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wd_ready", wd_ready, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        wd_valid = 1'b0; reset = 1'b0;
        step;
        check("mid_rst_release_ready", cmd_ready, 1);
        check("mid_rst_sel2", bus_sel, 0);
        do_read(2'd0, 2'd3, 1, -1, 0, 1'b0);

        // Randomized traffic against the expected-contents array.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(2'($urandom), 2'($urandom), 16'h0, 2);
            else
                do_read(2'($urandom), 2'($urandom), 3, -1, 0, 1'($urandom));
            if ($urandom_range(3, 0) == 0) idle_stray;
        end
        do_read(2'd0, 2'd3, 0, -1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
